// File: rtl/data_memory_arbiter_if.sv
// Bundle for the two requester ports and the data-memory port of the arbiter.
// The arbiter takes the slave view; requesters plus memory model take the master view.
interface data_memory_arbiter_if;
  logic       req0_valid, req0_we, req0_lock;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_we, req1_lock;
  logic [7:0] req1_addr, req1_wdata;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       mem_wen, mem_ren;
  logic [7:0] mem_address, mem_writeData, mem_readData;

  modport slave (
    input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    output mem_wen, mem_ren, mem_address, mem_writeData,
    input  mem_readData
  );

  modport master (
    output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    input  mem_wen, mem_ren, mem_address, mem_writeData,
    output mem_readData
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing a single-port 256x8 data memory between two requesters,
// with bounded lock sequences and a fixed one-cycle completion path.
module data_memory_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  data_memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;
  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  state_t          state, state_n;
  logic            last_grant, last_grant_n;
  logic [7:0]      lock_cnt, lock_cnt_n;
  logic            rsp_owner, rsp_pend, rsp_read;
  logic [1:0]      vld, we, lck, ready;
  logic [1:0][7:0] addr, wdata;
  logic            acc, g, own, cnt_done;

  assign vld   = {bus.req1_valid, bus.req0_valid};
  assign we    = {bus.req1_we,    bus.req0_we};
  assign lck   = {bus.req1_lock,  bus.req0_lock};
  assign addr  = {bus.req1_addr,  bus.req0_addr};
  assign wdata = {bus.req1_wdata, bus.req0_wdata};

  // ready is one-hot or zero, so the granted index is simply ready[1]
  assign acc      = |ready;
  assign g        = ready[1];
  assign own      = (state == LOCK1);
  assign cnt_done = (lock_cnt == CNT_LAST);

  always_comb begin
    ready = '0;
    case (state)
      ARB:     ready = (&vld) ? (last_grant ? 2'b01 : 2'b10) : vld;
      LOCK0:   ready[0] = vld[0];
      LOCK1:   ready[1] = vld[1];
      default: ready = '0;
    endcase
  end

  assign bus.req0_ready    = ready[0];
  assign bus.req1_ready    = ready[1];
  assign bus.mem_wen       = acc &  we[g];
  assign bus.mem_ren       = acc & ~we[g];
  assign bus.mem_address   = acc ? addr[g]  : 8'h00;
  assign bus.mem_writeData = acc ? wdata[g] : 8'h00;

  always_comb begin
    state_n      = state;
    lock_cnt_n   = lock_cnt;
    last_grant_n = acc ? g : last_grant;
    case (state)
      ARB: begin
        if (acc && lck[g]) begin
          state_n    = g ? LOCK1 : LOCK0;
          lock_cnt_n = 8'h00;
        end
      end
      LOCK0, LOCK1: begin
        if (!cnt_done) lock_cnt_n = lock_cnt + 8'd1;
        // forced release hands the next contention to the other requester
        if (cnt_done) begin
          state_n      = ARB;
          last_grant_n = own;
        end else if (!lck[own]) begin
          state_n = ARB;
        end
      end
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      last_grant <= 1'b1;
      lock_cnt   <= 8'h00;
      rsp_pend   <= 1'b0;
      rsp_owner  <= 1'b0;
      rsp_read   <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      lock_cnt   <= lock_cnt_n;
      rsp_pend   <= acc;
      if (acc) begin
        rsp_owner <= g;
        rsp_read  <= ~we[g];
      end
    end
  end

  assign bus.rsp0_valid = rsp_pend & ~rsp_owner;
  assign bus.rsp1_valid = rsp_pend &  rsp_owner;
  assign bus.rsp0_rdata = (bus.rsp0_valid & rsp_read) ? bus.mem_readData : 8'h00;
  assign bus.rsp1_rdata = (bus.rsp1_valid & rsp_read) ? bus.mem_readData : 8'h00;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a registered-read 256x8 memory model.
module tb_data_memory_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [256];
  logic [7:0] mem_rdata = 8'h00;

  data_memory_arbiter_if bus ();

  data_memory_arbiter #(.LOCK_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_wen) mem[bus.mem_address] <= bus.mem_writeData;
    if (bus.mem_ren) mem_rdata <= mem[bus.mem_address];
  end
  assign bus.mem_readData = mem_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, w0, l0, input logic [7:0] a0, d0,
                       input logic v1, w1, l1, input logic [7:0] a1, d1);
    bus.req0_valid = v0; bus.req0_we = w0; bus.req0_lock = l0;
    bus.req0_addr  = a0; bus.req0_wdata = d0;
    bus.req1_valid = v1; bus.req1_we = w1; bus.req1_lock = l1;
    bus.req1_addr  = a1; bus.req1_wdata = d1;
  endtask

  // one clock: change inputs just after the rising edge, return at the falling edge
  task automatic cyc(input logic v0, w0, l0, input logic [7:0] a0, d0,
                     input logic v1, w1, l1, input logic [7:0] a1, d1);
    @(posedge clk); #1;
    drive(v0, w0, l0, a0, d0, v1, w1, l1, a1, d1);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    // reset state
    @(negedge clk);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_rsp0",   bus.rsp0_valid, 0);
    chk("rst_rsp1",   bus.rsp1_valid, 0);
    chk("rst_wen",    bus.mem_wen, 0);
    chk("rst_ren",    bus.mem_ren, 0);
    chk("rst_addr",   bus.mem_address, 0);
    rst_n = 1'b1;

    // write then read-back from requester 0
    cyc(1, 1, 0, 8'h10, 8'h5A, 0, 0, 0, 8'h00, 8'h00);
    chk("wr_ready0", bus.req0_ready, 1);
    chk("wr_wen",    bus.mem_wen, 1);
    chk("wr_addr",   bus.mem_address, 8'h10);
    chk("wr_wdata",  bus.mem_writeData, 8'h5A);
    chk("wr_rsp0",   bus.rsp0_valid, 0);
    cyc(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("rd_ready0", bus.req0_ready, 1);
    chk("rd_ren",    bus.mem_ren, 1);
    chk("wrack_v",   bus.rsp0_valid, 1);
    chk("wrack_d",   bus.rsp0_rdata, 0);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("rd_rsp0_v", bus.rsp0_valid, 1);
    chk("rd_rsp0_d", bus.rsp0_rdata, 8'h5A);
    chk("rd_rsp1_v", bus.rsp1_valid, 0);

    // preload 0x01=0x11 and 0x02=0x22
    cyc(1, 1, 0, 8'h01, 8'h11, 0, 0, 0, 8'h00, 8'h00);
    chk("pre0_ready", bus.req0_ready, 1);
    cyc(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h02, 8'h22);
    chk("pre1_ready", bus.req1_ready, 1);

    // continuous contention alternates 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      chk($sformatf("rr%0d_ready0", i), bus.req0_ready, (i % 2 == 0));
      chk($sformatf("rr%0d_ready1", i), bus.req1_ready, (i % 2 == 1));
      if (i % 2 == 0) begin
        chk($sformatf("rr%0d_rsp1_v", i), bus.rsp1_valid, 1);
        chk($sformatf("rr%0d_rsp1_d", i), bus.rsp1_rdata, (i == 0) ? 8'h00 : 8'h22);
        chk($sformatf("rr%0d_rsp0_v", i), bus.rsp0_valid, 0);
      end else begin
        chk($sformatf("rr%0d_rsp0_v", i), bus.rsp0_valid, 1);
        chk($sformatf("rr%0d_rsp0_d", i), bus.rsp0_rdata, 8'h11);
        chk($sformatf("rr%0d_rsp1_v", i), bus.rsp1_valid, 0);
      end
    end
    cyc(1, 0, 0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("rr_tail_rsp1_d", bus.rsp1_rdata, 8'h22);
    chk("rr_tail_ready0", bus.req0_ready, 1);

    // locked read-modify-write by requester 1 while requester 0 waits
    cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 1, 8'h20, 8'h00);
    chk("lk_rd_ready0", bus.req0_ready, 0);
    chk("lk_rd_ready1", bus.req1_ready, 1);
    cyc(1, 0, 0, 8'h01, 8'h00, 1, 1, 0, 8'h20, 8'h77);
    chk("lk_wr_ready0", bus.req0_ready, 0);
    chk("lk_wr_ready1", bus.req1_ready, 1);
    chk("lk_wr_wdata",  bus.mem_writeData, 8'h77);
    chk("lk_rd_rsp1_v", bus.rsp1_valid, 1);
    chk("lk_rd_rsp1_d", bus.rsp1_rdata, 8'h00);
    cyc(1, 0, 0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("lk_post_ready0", bus.req0_ready, 1);
    chk("lk_wrack_v",     bus.rsp1_valid, 1);

    // lock held past LOCK_MAX=4: forced release on the 5th cycle
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 1, 8'h20, 8'h00);
      chk($sformatf("to%0d_ready0", k), bus.req0_ready, 0);
      chk($sformatf("to%0d_ready1", k), bus.req1_ready, 1);
      if (k > 0) chk($sformatf("to%0d_rsp1_d", k), bus.rsp1_rdata, 8'h77);
    end
    cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 1, 8'h20, 8'h00);
    chk("to5_ready0", bus.req0_ready, 1);
    chk("to5_ready1", bus.req1_ready, 0);
    chk("to5_rsp1_d", bus.rsp1_rdata, 8'h77);
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("to6_rsp0_v", bus.rsp0_valid, 1);
    chk("to6_rsp0_d", bus.rsp0_rdata, 8'h11);

    // reset drops the pending response and restores requester-0 priority
    cyc(1, 0, 0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("rr_pre_ready0", bus.req0_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("mrst_rsp0_v", bus.rsp0_valid, 0);
    chk("mrst_rsp0_d", bus.rsp0_rdata, 0);
    chk("mrst_rsp1_v", bus.rsp1_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_rel_rsp0_v", bus.rsp0_valid, 0);
    cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
    chk("mrst_ready0", bus.req0_ready, 1);
    chk("mrst_ready1", bus.req1_ready, 0);

    // idle
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    chk("idle_last_rsp0", bus.rsp0_valid, 1);
    for (int j = 0; j < 3; j++) begin
      cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      chk($sformatf("idle%0d_wen", j),  bus.mem_wen, 0);
      chk($sformatf("idle%0d_ren", j),  bus.mem_ren, 0);
      chk($sformatf("idle%0d_addr", j), bus.mem_address, 0);
      chk($sformatf("idle%0d_rsp0", j), bus.rsp0_valid, 0);
      chk($sformatf("idle%0d_rsp1", j), bus.rsp1_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
